// File: rtl/blimp_v6_test_pkg.sv
// blimp_v6_test_pkg: shared types and constants for the BlimpV6 test harness.
// Memory messages carry the opaque tag at a fixed maximum width; only the low
// p_opaq_bits of it are ever non-zero, so one struct type serves every
// opaque-width configuration.
package blimp_v6_test_pkg;
    localparam int MEM_WORDS = 16384;
    localparam int OPAQ_MAX = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0200;
    typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_op_e;
    typedef struct packed {
        mem_op_e op;
        logic [OPAQ_MAX-1:0] opaque;
        logic [31:0] addr;
        logic [1:0] len;
        logic [31:0] data;
    } mem_req_t;
    typedef struct packed {
        mem_op_e op;
        logic [OPAQ_MAX-1:0] opaque;
        logic [1:0] len;
        logic [31:0] data;
    } mem_resp_t;
    // len encoding: 0 = word, 1 = byte, 2 = halfword; lanes are little-endian
    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
        return len == 2'd1 ? 4'b0001 << off : len == 2'd2 ? 4'b0011 << off : 4'b1111;
    endfunction
endpackage

// File: rtl/blimp_test_mem_port.sv
// blimp_test_mem_port: one throttled val/rdy port onto the shared test memory.
// Ports: req_* request stream in, resp_* response stream out, wr_*/idx_o
// drive the shared array write, rd_data_i is the addressed word (old value).
module blimp_test_mem_port
    import blimp_v6_test_pkg::*;
#(
    parameter int p_send_delay = 1,
    parameter int p_recv_delay = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_val_i,
    output logic        req_rdy_o,
    input  mem_req_t    req_i,
    output logic        resp_val_o,
    input  logic        resp_rdy_i,
    output mem_resp_t   resp_o,
    output logic        wr_en_o,
    output logic [13:0] idx_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_be_o,
    input  logic [31:0] rd_data_i
);
    localparam logic [7:0] SEND_D = 8'(p_send_delay);
    localparam logic [7:0] RECV_D = 8'(p_recv_delay);
    mem_resp_t fifo_q [4];
    logic [1:0] wp_q, rp_q;
    logic [2:0] cnt_q;
    logic [7:0] send_cnt_q, recv_cnt_q;
    logic acc, pop;
    logic [4:0] sh;
    logic [31:0] rd_sh;
    mem_resp_t resp_d;
    logic unused_ok;
    assign unused_ok = &{1'b0, req_i.addr[31:16]};
    assign resp_val_o = cnt_q != 3'd0 && recv_cnt_q >= RECV_D;
    assign pop = resp_val_o && resp_rdy_i;
    // a full queue may still accept when its head leaves this cycle
    assign req_rdy_o = (cnt_q != 3'd4 || pop) && send_cnt_q >= SEND_D;
    assign acc = req_val_i && req_rdy_o;
    assign sh = {req_i.addr[1:0], 3'b000};
    assign idx_o = req_i.addr[15:2];
    assign wr_en_o = acc && req_i.op == MEM_WRITE;
    assign wr_be_o = byte_en(req_i.len, req_i.addr[1:0]);
    assign wr_data_o = req_i.data << sh;
    assign rd_sh = rd_data_i >> sh;
    assign resp_o = fifo_q[rp_q];
    always_comb begin
        resp_d = '{op: req_i.op, opaque: req_i.opaque, len: req_i.len, data: 32'd0};
        resp_d.data = req_i.op == MEM_WRITE ? 32'd0 :
                      req_i.len == 2'd1 ? {24'd0, rd_sh[7:0]} :
                      req_i.len == 2'd2 ? {16'd0, rd_sh[15:0]} : rd_sh;
    end
    always_ff @(posedge clk) begin
        if (acc) fifo_q[wp_q] <= resp_d;
    end
    // interval counters saturate at the delay, so reset leaves both ports ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= 2'd0;
            rp_q <= 2'd0;
            cnt_q <= 3'd0;
            send_cnt_q <= SEND_D;
            recv_cnt_q <= RECV_D;
        end else begin
            if (acc) wp_q <= wp_q + 2'd1;
            if (pop) rp_q <= rp_q + 2'd1;
            cnt_q <= cnt_q + 3'(acc) - 3'(pop);
            send_cnt_q <= acc ? 8'd1 : send_cnt_q < SEND_D ? send_cnt_q + 8'd1 : send_cnt_q;
            recv_cnt_q <= pop ? 8'd1 : recv_cnt_q < RECV_D ? recv_cnt_q + 8'd1 : recv_cnt_q;
        end
    end
endmodule

// File: rtl/blimp_v6.sv
// blimp_v6: BlimpV6 RV32 core model with one outstanding memory access per port.
// Ports: imem_*/dmem_* val/rdy memory streams, commit_* retire trace (registered).
// Supports LUI, AUIPC, JAL, JALR, OP, OP-IMM, loads and stores; other opcodes
// retire as no-ops. Opaque tags follow a sequence counter so stale replies are dropped.
module blimp_v6
    import blimp_v6_test_pkg::*;
#(
    parameter int p_opaq_bits = 8,
    parameter int p_seq_num_bits = 5,
    parameter int p_num_phys_regs = 36
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_val_o,
    input  logic        imem_req_rdy_i,
    output mem_req_t    imem_req_o,
    input  logic        imem_resp_val_i,
    output logic        imem_resp_rdy_o,
    input  mem_resp_t   imem_resp_i,
    output logic        dmem_req_val_o,
    input  logic        dmem_req_rdy_i,
    output mem_req_t    dmem_req_o,
    input  logic        dmem_resp_val_i,
    output logic        dmem_resp_rdy_o,
    input  mem_resp_t   dmem_resp_i,
    output logic        commit_val_o,
    output logic [31:0] commit_pc_o,
    output logic        commit_wen_o,
    output logic [4:0]  commit_waddr_o,
    output logic [31:0] commit_wdata_o
);
    localparam int PW = $clog2(p_num_phys_regs);
    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
    localparam logic [6:0] OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_OPIMM = 7'h13, OPC_OP = 7'h33;
    typedef enum logic [1:0] {S_FETCH, S_IWAIT, S_DREQ, S_DWAIT} state_e;
    state_e state_q;
    logic [31:0] pc_q, mpc_q, daddr_q, ddata_q;
    logic [p_seq_num_bits-1:0] seq_q;
    logic [31:0] rf_q [p_num_phys_regs];
    logic [4:0] rd_q;
    logic [2:0] f3_q;
    mem_op_e dop_q;
    logic [1:0] dlen_q;
    logic commit_val_q, commit_wen_q;
    logic [31:0] commit_pc_q, commit_wdata_q;
    logic [4:0] commit_waddr_q;
    logic [31:0] tag, inst, r1, r2, b, imm_i, imm_s, imm_u, imm_j, alu, res, next_pc, maddr, ld, wd;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] shamt, wa;
    logic [1:0] mlen;
    logic imatch, dmatch, is_mem, writes, cv, rf_we;
    assign tag = 32'(p_opaq_bits'(seq_q));
    assign imem_req_val_o = state_q == S_FETCH;
    assign imem_req_o = '{op: MEM_READ, opaque: tag, addr: pc_q, len: 2'd0, data: 32'd0};
    assign imem_resp_rdy_o = state_q == S_IWAIT;
    assign dmem_req_val_o = state_q == S_DREQ;
    assign dmem_req_o = '{op: dop_q, opaque: tag, addr: daddr_q, len: dlen_q, data: ddata_q};
    assign dmem_resp_rdy_o = state_q == S_DWAIT;
    assign commit_val_o = commit_val_q;
    assign commit_pc_o = commit_pc_q;
    assign commit_wen_o = commit_wen_q;
    assign commit_waddr_o = commit_waddr_q;
    assign commit_wdata_o = commit_wdata_q;
    always_comb begin
        inst = imem_resp_i.data;
        opc = inst[6:0];
        f3 = inst[14:12];
        r1 = inst[19:15] == 5'd0 ? 32'd0 : rf_q[PW'(inst[19:15])];
        r2 = inst[24:20] == 5'd0 ? 32'd0 : rf_q[PW'(inst[24:20])];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_u = {inst[31:12], 12'd0};
        imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b = opc == OPC_OP ? r2 : imm_i;
        shamt = b[4:0];
        // inst[30] selects SUB only for register-register ops; for SRAI/SRA it selects arithmetic shift
        alu = f3 == 3'd0 ? (opc == OPC_OP && inst[30] ? r1 - b : r1 + b) :
              f3 == 3'd1 ? r1 << shamt :
              f3 == 3'd2 ? {31'd0, $signed(r1) < $signed(b)} :
              f3 == 3'd3 ? {31'd0, r1 < b} :
              f3 == 3'd4 ? r1 ^ b :
              f3 == 3'd5 ? (inst[30] ? 32'($signed(r1) >>> shamt) : r1 >> shamt) :
              f3 == 3'd6 ? r1 | b : r1 & b;
        res = opc == OPC_LUI ? imm_u : opc == OPC_AUIPC ? pc_q + imm_u :
              opc == OPC_JAL || opc == OPC_JALR ? pc_q + 32'd4 : alu;
        writes = opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR ||
                 opc == OPC_OP || opc == OPC_OPIMM;
        next_pc = opc == OPC_JAL ? pc_q + imm_j : opc == OPC_JALR ? (r1 + imm_i) & ~32'd1 : pc_q + 32'd4;
        is_mem = opc == OPC_LOAD || opc == OPC_STORE;
        maddr = r1 + (opc == OPC_STORE ? imm_s : imm_i);
        mlen = f3[1:0] == 2'd0 ? 2'd1 : f3[1:0] == 2'd1 ? 2'd2 : 2'd0;
        // memory zero-extends; signed loads extend here
        ld = f3_q == 3'd0 ? {{24{dmem_resp_i.data[7]}}, dmem_resp_i.data[7:0]} :
             f3_q == 3'd1 ? {{16{dmem_resp_i.data[15]}}, dmem_resp_i.data[15:0]} : dmem_resp_i.data;
        imatch = imem_resp_val_i && imem_resp_i.opaque == tag && imem_resp_i.op == MEM_READ &&
                 imem_resp_i.len == 2'd0;
        dmatch = dmem_resp_val_i && dmem_resp_i.opaque == tag && dmem_resp_i.op == dop_q &&
                 dmem_resp_i.len == dlen_q;
        cv = (state_q == S_IWAIT && imatch && !is_mem) || (state_q == S_DWAIT && dmatch);
        wa = state_q == S_IWAIT ? inst[11:7] : rd_q;
        wd = state_q == S_IWAIT ? res : ld;
        rf_we = cv && wa != 5'd0 && (state_q == S_IWAIT ? writes : dop_q == MEM_READ);
    end
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[PW'(wa)] <= wd;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q <= RESET_PC;
            mpc_q <= 32'd0;
            seq_q <= '0;
            rd_q <= 5'd0;
            f3_q <= 3'd0;
            dop_q <= MEM_READ;
            daddr_q <= 32'd0;
            ddata_q <= 32'd0;
            dlen_q <= 2'd0;
            commit_val_q <= 1'b0;
            commit_pc_q <= 32'd0;
            commit_wen_q <= 1'b0;
            commit_waddr_q <= 5'd0;
            commit_wdata_q <= 32'd0;
        end else begin
            commit_val_q <= cv;
            if (cv) begin
                commit_pc_q <= state_q == S_IWAIT ? pc_q : mpc_q;
                commit_wen_q <= rf_we;
                commit_waddr_q <= rf_we ? wa : 5'd0;
                commit_wdata_q <= rf_we ? wd : 32'd0;
            end
            case (state_q)
                S_FETCH: if (imem_req_rdy_i) state_q <= S_IWAIT;
                S_IWAIT: if (imem_resp_val_i) begin
                    // a reply with the wrong tag is discarded and the fetch reissued
                    state_q <= !imatch ? S_FETCH : is_mem ? S_DREQ : S_FETCH;
                    if (imatch) begin
                        seq_q <= seq_q + 1'b1;
                        pc_q <= next_pc;
                        mpc_q <= pc_q;
                        dop_q <= opc == OPC_STORE ? MEM_WRITE : MEM_READ;
                        daddr_q <= maddr;
                        ddata_q <= r2;
                        dlen_q <= mlen;
                        rd_q <= inst[11:7];
                        f3_q <= f3;
                    end
                end
                S_DREQ: if (dmem_req_rdy_i) state_q <= S_DWAIT;
                S_DWAIT: if (dmem_resp_val_i) begin
                    state_q <= dmatch ? S_FETCH : S_DREQ;
                    if (dmatch) seq_q <= seq_q + 1'b1;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end
endmodule

// File: rtl/blimp_v6_test_harness.sv
// blimp_v6_test_harness: BlimpV6 core on a shared 64 KiB behavioural memory.
// Ports: clk, rst_n (async active-low), init_* word-load port (works in reset),
// trace_* combinational view of the core commit stream, zeroed when idle.
module blimp_v6_test_harness
    import blimp_v6_test_pkg::*;
#(
    parameter int p_opaq_bits = 8,
    parameter int p_seq_num_bits = 5,
    parameter int p_num_phys_regs = 36,
    parameter int p_mem_send_intv_delay = 1,
    parameter int p_mem_recv_intv_delay = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_en,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data,
    output logic        trace_val,
    output logic [31:0] trace_pc,
    output logic        trace_wen,
    output logic [4:0]  trace_waddr,
    output logic [31:0] trace_wdata
);
    logic [31:0] mem_q [MEM_WORDS];
    mem_req_t imem_req, dmem_req;
    mem_resp_t imem_resp, dmem_resp;
    logic imem_req_val, imem_req_rdy, imem_resp_val, imem_resp_rdy;
    logic dmem_req_val, dmem_req_rdy, dmem_resp_val, dmem_resp_rdy;
    logic [1:0] wr_en;
    logic [13:0] idx [2];
    logic [31:0] wr_data [2];
    logic [31:0] rd_data [2];
    logic [3:0] wr_be [2];
    logic c_val, c_wen;
    logic [31:0] c_pc, c_wdata;
    logic [4:0] c_waddr;
    logic unused_ok;
    assign unused_ok = &{1'b0, init_addr[31:16], init_addr[1:0]};
    assign rd_data[0] = mem_q[idx[0]];
    assign rd_data[1] = mem_q[idx[1]];
    // later writes win: dmem over imem, and init over both
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 4; b++)
                if (wr_en[p] && wr_be[p][b]) mem_q[idx[p]][8*b +: 8] <= wr_data[p][8*b +: 8];
        if (init_en) mem_q[init_addr[15:2]] <= init_data;
    end
    blimp_test_mem_port #(.p_send_delay(p_mem_send_intv_delay), .p_recv_delay(p_mem_recv_intv_delay)) u_imem (
        .clk(clk), .rst_n(rst_n),
        .req_val_i(imem_req_val), .req_rdy_o(imem_req_rdy), .req_i(imem_req),
        .resp_val_o(imem_resp_val), .resp_rdy_i(imem_resp_rdy), .resp_o(imem_resp),
        .wr_en_o(wr_en[0]), .idx_o(idx[0]), .wr_data_o(wr_data[0]), .wr_be_o(wr_be[0]),
        .rd_data_i(rd_data[0])
    );
    blimp_test_mem_port #(.p_send_delay(p_mem_send_intv_delay), .p_recv_delay(p_mem_recv_intv_delay)) u_dmem (
        .clk(clk), .rst_n(rst_n),
        .req_val_i(dmem_req_val), .req_rdy_o(dmem_req_rdy), .req_i(dmem_req),
        .resp_val_o(dmem_resp_val), .resp_rdy_i(dmem_resp_rdy), .resp_o(dmem_resp),
        .wr_en_o(wr_en[1]), .idx_o(idx[1]), .wr_data_o(wr_data[1]), .wr_be_o(wr_be[1]),
        .rd_data_i(rd_data[1])
    );
    blimp_v6 #(.p_opaq_bits(p_opaq_bits), .p_seq_num_bits(p_seq_num_bits), .p_num_phys_regs(p_num_phys_regs)) u_core (
        .clk(clk), .rst_n(rst_n),
        .imem_req_val_o(imem_req_val), .imem_req_rdy_i(imem_req_rdy), .imem_req_o(imem_req),
        .imem_resp_val_i(imem_resp_val), .imem_resp_rdy_o(imem_resp_rdy), .imem_resp_i(imem_resp),
        .dmem_req_val_o(dmem_req_val), .dmem_req_rdy_i(dmem_req_rdy), .dmem_req_o(dmem_req),
        .dmem_resp_val_i(dmem_resp_val), .dmem_resp_rdy_o(dmem_resp_rdy), .dmem_resp_i(dmem_resp),
        .commit_val_o(c_val), .commit_pc_o(c_pc), .commit_wen_o(c_wen),
        .commit_waddr_o(c_waddr), .commit_wdata_o(c_wdata)
    );
    assign trace_val = c_val;
    assign trace_pc = c_val ? c_pc : 32'd0;
    assign trace_wen = c_val && c_wen && c_waddr != 5'd0;
    assign trace_waddr = c_val ? c_waddr : 5'd0;
    assign trace_wdata = c_val ? c_wdata : 32'd0;
endmodule

// File: tb/tb_blimp_v6_test_harness.sv
// tb_blimp_v6_test_harness: directed program run on five harness configurations.
module tb_blimp_v6_test_harness;
    localparam int N = 14;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic init_en = 1'b0;
    logic [31:0] init_addr = 32'd0, init_data = 32'd0;
    logic [4:0] tv, twen;
    logic [31:0] tpc [5];
    logic [31:0] twd [5];
    logic [4:0] twa [5];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int cnt [5];
    int last_acc [5];
    int last_rsp [5];
    int min_acc [5] = '{1000, 1000, 1000, 1000, 1000};
    int min_rsp [5] = '{1000, 1000, 1000, 1000, 1000};
    logic [69:0] got_log [5][N];
    logic [69:0] exp_tab [N];
    logic [31:0] prog [N];
    always #5 clk = ~clk;

    blimp_v6_test_harness u_a (.clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .trace_val(tv[0]), .trace_pc(tpc[0]), .trace_wen(twen[0]), .trace_waddr(twa[0]), .trace_wdata(twd[0]));
    blimp_v6_test_harness #(4, 3, 33, 1, 1) u_b (.clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .trace_val(tv[1]), .trace_pc(tpc[1]), .trace_wen(twen[1]), .trace_waddr(twa[1]), .trace_wdata(twd[1]));
    blimp_v6_test_harness #(32, 4, 50, 3, 1) u_c (.clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .trace_val(tv[2]), .trace_pc(tpc[2]), .trace_wen(twen[2]), .trace_waddr(twa[2]), .trace_wdata(twd[2]));
    blimp_v6_test_harness #(2, 2, 48, 1, 3) u_d (.clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .trace_val(tv[3]), .trace_pc(tpc[3]), .trace_wen(twen[3]), .trace_waddr(twa[3]), .trace_wdata(twd[3]));
    blimp_v6_test_harness #(4, 6, 42, 3, 3) u_e (.clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .trace_val(tv[4]), .trace_pc(tpc[4]), .trace_wen(twen[4]), .trace_waddr(twa[4]), .trace_wdata(twd[4]));

    wire [4:0] iacc = {u_e.imem_req_val & u_e.imem_req_rdy, u_d.imem_req_val & u_d.imem_req_rdy,
                       u_c.imem_req_val & u_c.imem_req_rdy, u_b.imem_req_val & u_b.imem_req_rdy,
                       u_a.imem_req_val & u_a.imem_req_rdy};
    wire [4:0] irsp = {u_e.imem_resp_val & u_e.imem_resp_rdy, u_d.imem_resp_val & u_d.imem_resp_rdy,
                       u_c.imem_resp_val & u_c.imem_resp_rdy, u_b.imem_resp_val & u_b.imem_resp_rdy,
                       u_a.imem_resp_val & u_a.imem_resp_rdy};
    wire [4:0] rv = {u_e.imem_resp_val | u_e.dmem_resp_val, u_d.imem_resp_val | u_d.dmem_resp_val,
                     u_c.imem_resp_val | u_c.dmem_resp_val, u_b.imem_resp_val | u_b.dmem_resp_val,
                     u_a.imem_resp_val | u_a.dmem_resp_val};

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (!rst_n) begin
                cnt[i] = 0;
                last_acc[i] = -1;
                last_rsp[i] = -1;
            end else begin
                if (tv[i] && cnt[i] < N) begin
                    got_log[i][cnt[i]] = {tpc[i], twen[i], twa[i], twd[i]};
                    cnt[i]++;
                end
                if (iacc[i]) begin
                    if (last_acc[i] >= 0 && cyc - last_acc[i] < min_acc[i]) min_acc[i] = cyc - last_acc[i];
                    last_acc[i] = cyc;
                end
                if (irsp[i]) begin
                    if (last_rsp[i] >= 0 && cyc - last_rsp[i] < min_rsp[i]) min_rsp[i] = cyc - last_rsp[i];
                    last_rsp[i] = cyc;
                end
            end
        end
    end

    task automatic put_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        init_en = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_en = 1'b0;
    endtask

    task automatic wait_all(input string tag, input int need);
        int n = 0;
        logic done = 1'b0;
        while (!done && n < 3000) begin
            @(posedge clk);
            n++;
            done = 1'b1;
            for (int i = 0; i < 5; i++) if (cnt[i] < need) done = 1'b0;
        end
        chk(tag, 70'(done), 70'd1);
    endtask

    task automatic check_logs(input string run);
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < N; k++)
                chk($sformatf("%s_c%0d_%0d", run, i, k),
                    exp_tab[k][37] ? got_log[i][k] : {got_log[i][k][69:37], 37'd0}, exp_tab[k]);
    endtask

    initial begin
        prog = '{32'h00500093, 32'h7FF00093, 32'h00108113, 32'h80010193, 32'h800000B7, 32'hFFF08093,
                 32'h00108113, 32'hFFF00293, 32'h00700013, 32'h00001337, 32'h0AA00393, 32'h007300A3,
                 32'h00032403, 32'h0000006F};
        exp_tab = '{{32'h200, 1'b1, 5'd1, 32'h5},        {32'h204, 1'b1, 5'd1, 32'h7FF},
                    {32'h208, 1'b1, 5'd2, 32'h800},      {32'h20C, 1'b1, 5'd3, 32'h0},
                    {32'h210, 1'b1, 5'd1, 32'h80000000}, {32'h214, 1'b1, 5'd1, 32'h7FFFFFFF},
                    {32'h218, 1'b1, 5'd2, 32'h80000000}, {32'h21C, 1'b1, 5'd5, 32'hFFFFFFFF},
                    {32'h220, 1'b0, 5'd0, 32'h0},        {32'h224, 1'b1, 5'd6, 32'h1000},
                    {32'h228, 1'b1, 5'd7, 32'hAA},       {32'h22C, 1'b0, 5'd0, 32'h0},
                    {32'h230, 1'b1, 5'd8, 32'h1122AA44}, {32'h234, 1'b0, 5'd0, 32'h0}};
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trace_val", 70'(tv), 70'd0);
        chk("rst_resp_val", 70'(rv), 70'd0);
        for (int k = 0; k < N; k++) put_word(32'h200 + 32'(4 * k), prog[k]);
        put_word(32'h1000, 32'h11223344);
        chk("rst_hold_trace_val", 70'(tv), 70'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_all("run1_done", N);
        check_logs("run1");
        chk("send_gap_d1", 70'(min_acc[0]), 70'd2);
        chk("send_gap_d3", 70'(min_acc[2]), 70'd3);
        chk("send_gap_d3d3", 70'(min_acc[4] >= 3), 70'd1);
        chk("recv_gap_d3", 70'(min_rsp[3]), 70'd3);
        chk("recv_gap_d3d3", 70'(min_rsp[4] >= 3), 70'd1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_all("mid_reach", 5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_trace_val", 70'(tv), 70'd0);
        chk("mid_rst_resp_val", 70'(rv), 70'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_all("run2_done", N);
        check_logs("run2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
